config_loader: RTL and testbench



---
 rtl/config_loader.sv | 78 +++++++
 tb/tb_config_loader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// config_loader: streams a tile bitstream into a staging register, verifies a
// trailing XOR checksum word and commits the staging register atomically to config_out.
module config_loader #(
    parameter int CONFIG_WIDTH = 146,
    parameter int WORD_WIDTH = 8,
    localparam int NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    start,
    input  logic [WORD_WIDTH-1:0]   data_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    config_valid,
    output logic                    busy,
    output logic                    error
);
    localparam int CW = $clog2(NUM_WORDS + 1);
    localparam int OW = $clog2(NUM_WORDS * WORD_WIDTH);
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR} state_t;
    state_t state, state_next;
    logic [CW-1:0] count;
    logic [WORD_WIDTH-1:0] checksum;
    logic [CONFIG_WIDTH-1:0] staging, staging_next;
    logic [OW-1:0] offset;
    logic xfer, last_word, match;
    assign busy = state == LOAD || state == CHECK;
    assign data_ready = busy && !start;
    assign xfer = data_valid && data_ready;
    assign last_word = count == CW'(NUM_WORDS - 1);
    assign match = data_in == checksum;
    assign offset = OW'(count) * OW'(WORD_WIDTH);
    // shifting in a config-wide frame drops the final word's bits above CONFIG_WIDTH
    assign staging_next = (staging & ~({{(CONFIG_WIDTH-WORD_WIDTH){1'b0}}, {WORD_WIDTH{1'b1}}} << offset))
                        | ({{(CONFIG_WIDTH-WORD_WIDTH){1'b0}}, data_in} << offset);
    always_comb begin
        state_next = state;
        if (start)
            state_next = LOAD;
        else if (xfer && state == LOAD)
            state_next = last_word ? CHECK : LOAD;
        else if (xfer && state == CHECK)
            state_next = match ? DONE : ERROR;
    end
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset)
            state <= IDLE;
        else
            state <= state_next;
    end
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            count <= '0;
            checksum <= '0;
            staging <= '0;
            config_out <= '0;
            config_valid <= 1'b0;
            error <= 1'b0;
        end else if (start) begin
            count <= '0;
            checksum <= '0;
            config_valid <= 1'b0;
            error <= 1'b0;
        end else if (xfer && state == LOAD) begin
            staging <= staging_next;
            checksum <= checksum ^ data_in;
            count <= count + 1'b1;
        end else if (xfer && state == CHECK) begin
            if (match) begin
                config_out <= staging;
                config_valid <= 1'b1;
            end else begin
                error <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: directed and randomized loads checked against a bit-level model.
module tb_config_loader;
    localparam int CFG = 146;
    localparam int NW = 19;
    logic clock, nreset, start, data_valid;
    logic [7:0] data_in;
    logic data_ready, config_valid, busy, error;
    logic [CFG-1:0] config_out;
    int checks = 0, failures = 0, xfers = 0, pi = 0;
    logic [7:0] words [NW];
    logic [CFG-1:0] exp_cfg, old_cfg;
    logic exp_valid, exp_err;

    config_loader dut (
        .clock(clock), .nreset(nreset), .start(start), .data_in(data_in),
        .data_valid(data_valid), .data_ready(data_ready), .config_out(config_out),
        .config_valid(config_valid), .busy(busy), .error(error)
    );

    initial clock = 0;
    always #5 clock = ~clock;
    always @(posedge clock) if (data_valid && data_ready) xfers++;

    task automatic chk(input string tag, input logic [CFG-1:0] obs, input logic [CFG-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [CFG-1:0] model_cfg();
        logic [CFG-1:0] r;
        for (int i = 0; i < CFG; i++) r[i] = words[i / 8][i % 8];
        return r;
    endfunction

    function automatic logic [7:0] model_xor();
        logic [7:0] x = 0;
        for (int k = 0; k < NW; k++) x ^= words[k];
        return x;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_cfg"}, config_out, exp_cfg);
        chk({tag, "_valid"}, config_valid, exp_valid);
        chk({tag, "_error"}, error, exp_err);
    endtask

    task automatic send(input logic [7:0] w, input int mode);
        bit took = 0;
        int n = 0;
        while (!took && n < 200) begin
            data_in = w;
            data_valid = mode == 0 ? 1'b1 : mode == 1 ? (pi % 4 == 0 || pi % 4 == 3) : 1'($urandom_range(0, 1));
            pi++;
            n++;
            #1 took = data_valid && data_ready;
            @(negedge clock);
        end
        data_valid = 0;
        chk("send_timeout", took, 1'b1);
    endtask

    task automatic pulse_start();
        start = 1;
        data_valid = 0;
        @(negedge clock);
        start = 0;
        exp_valid = 0;
        exp_err = 0;
    endtask

    task automatic load(input int mode, input bit bad, input logic [7:0] bad_chk);
        logic [7:0] c = bad ? bad_chk : model_xor();
        for (int k = 0; k < NW; k++) send(words[k], mode);
        send(c, mode);
        if (c == model_xor()) begin
            exp_cfg = model_cfg();
            exp_valid = 1;
        end else exp_err = 1;
    endtask

    task automatic do_reset();
        nreset = 0;
        #1;
        exp_cfg = 0;
        exp_valid = 0;
        exp_err = 0;
        @(negedge clock);
        nreset = 1;
    endtask

    initial begin
        int base;
        nreset = 0; start = 0; data_valid = 0; data_in = 0;
        exp_cfg = 0; exp_valid = 0; exp_err = 0;
        repeat (2) @(negedge clock);
        check_outputs("reset");
        chk("reset_busy", busy, 1'b0);
        chk("reset_ready", data_ready, 1'b0);
        nreset = 1;
        @(negedge clock);
        // good load, continuous valid
        for (int k = 0; k < NW; k++) words[k] = 8'(k + 1);
        pulse_start();
        chk("start_busy", busy, 1'b1);
        load(0, 0, 0);
        check_outputs("good");
        chk("good_byte0", config_out[7:0], 8'h01);
        chk("good_byte1", config_out[15:8], 8'h02);
        chk("good_top", config_out[145:144], 2'b11);
        chk("good_busy", busy, 1'b0);
        // bad checksum from a fresh reset
        do_reset();
        pulse_start();
        load(0, 1, 8'h5A);
        check_outputs("bad");
        chk("bad_cfg_zero", config_out, '0);
        chk("bad_ready", data_ready, 1'b0);
        chk("bad_busy", busy, 1'b0);
        // backpressure 1,0,0,1
        pulse_start();
        chk("restart_err_clr", error, 1'b0);
        base = xfers;
        pi = 0;
        load(1, 0, 0);
        check_outputs("bp");
        chk("bp_xfers", xfers - base, 20);
        // abort after 10 words
        pulse_start();
        for (int k = 0; k < 10; k++) send(words[k] ^ 8'h3C, 0);
        start = 1;
        data_valid = 1;
        data_in = 8'hAA;
        #1 chk("abort_ready", data_ready, 1'b0);
        base = xfers;
        @(negedge clock);
        start = 0;
        data_valid = 0;
        chk("abort_no_xfer", xfers - base, 0);
        chk("abort_cfg_kept", config_out, exp_cfg);
        for (int k = 0; k < NW; k++) words[k] = 8'(8'hFF - k);
        load(0, 0, 0);
        check_outputs("abort");
        chk("abort_byte0", config_out[7:0], 8'hFF);
        // reset mid-load after a completed good load
        pulse_start();
        for (int k = 0; k < 5; k++) send(8'(k * 7), 0);
        do_reset();
        check_outputs("midrst");
        chk("midrst_busy", busy, 1'b0);
        base = xfers;
        data_valid = 1;
        repeat (3) @(negedge clock);
        data_valid = 0;
        chk("midrst_no_xfer", xfers - base, 0);
        // randomized loads with random gaps, reload behaviour, occasional bad checksum
        for (int it = 0; it < 6; it++) begin
            bit bad = it % 3 == 2;
            for (int k = 0; k < NW; k++) words[k] = 8'($urandom_range(0, 255));
            old_cfg = exp_cfg;
            pulse_start();
            chk("reload_valid_clr", config_valid, 1'b0);
            chk("reload_cfg_held", config_out, old_cfg);
            load(2, bad, model_xor() ^ 8'(1 << (it % 8)));
            check_outputs("rand");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
